// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Contents: FSM state encoding, the NOP instruction word that squashed
// pipeline registers load, the hard-wired zero register index and the
// width of the bubble/flush down-counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    MWAIT  = 2'd3
  } state_e;

  // sll $0,$0,0 -- the canonical MIPS NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Down-counter width; holds up to 7 remaining bubble/flush cycles.
  localparam int CNT_STATE_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   - core clock, rising edge
//   rst   - asynchronous reset, active-low, clears the count
//   clear - synchronous clear, takes priority over inc
//   inc   - count this cycle
//   count - current value; sticks at all-ones instead of wrapping
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_C = {W{1'b1}};

  logic [W-1:0] count_r;

  // Count register: clear, then saturating increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != MAX_C)) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer for the 5-stage MIPS core. Handles what the
// forwarding unit cannot: load-use stalls, taken-branch squash and
// data-memory wait states. Outputs are Mealy so a stall acts in the same
// cycle the hazard is seen.
// Ports:
//   clk, rst                 - clock (rising edge), async reset active-low
//   D_rs, D_rt, D_usesRt     - decode-stage source operands
//   X_rd, X_memRead          - execute-stage destination / load flag
//   X_branchTaken            - branch resolved taken in EX
//   M_memReq, M_memReady     - MEM-stage data memory handshake
//   pc_write, FD_write       - PC and IF/ID enables
//   FD_flush, DX_bubble      - IF/ID and ID/EX NOP insertion
//   XM_hold                  - freeze EX/MEM and MEM/WB
//   stall_count              - saturating count of cycles with pc_write=0
// Optional (macro HAZARD_PERF_EN):
//   flush_count              - saturating count of cycles with FD_flush=1
//   memwait_count            - saturating count of cycles with XM_hold=1
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_usesRt,
  input  logic [4:0]       X_rd,
  input  logic             X_memRead,
  input  logic             X_branchTaken,
  input  logic             M_memReq,
  input  logic             M_memReady,
  output logic             pc_write,
  output logic             FD_write,
  output logic             FD_flush,
  output logic             DX_bubble,
  output logic             XM_hold,
  output logic [CNT_W-1:0] stall_count
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_count
`endif
);

  // Counter preload leaves the first bubble/flush cycle to the RUN state.
  localparam logic [CNT_STATE_W-1:0] LOAD_INIT  = CNT_STATE_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_STATE_W-1:0] FLUSH_INIT = CNT_STATE_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_STATE_W-1:0] CNT_ONE    = CNT_STATE_W'(1);

  state_e                 state_r, state_nxt_s;
  state_e                 ret_state_r, ret_nxt_s;
  state_e                 eff_state_s;
  logic [CNT_STATE_W-1:0] cnt_r, cnt_nxt_s;
  logic                   memwait_s, loaduse_s;
  logic                   pc_write_s, fd_write_s, fd_flush_s, dx_bubble_s, xm_hold_s;

  assign memwait_s = M_memReq & ~M_memReady;
  assign loaduse_s = X_memRead & (X_rd != REG_ZERO) &
                     ((X_rd == D_rs) | (D_usesRt & (X_rd == D_rt)));

  // Leaving MWAIT applies the saved state's rule in that same cycle.
  assign eff_state_s = (state_r == MWAIT) ? ret_state_r : state_r;

  // State, return state and bubble/flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_nxt_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

  // Next-state and Mealy output decode; priority memwait > branch > loaduse.
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_state_r;
    cnt_nxt_s   = cnt_r;
    pc_write_s  = 1'b0;
    fd_write_s  = 1'b0;
    fd_flush_s  = 1'b0;
    dx_bubble_s = 1'b0;
    xm_hold_s   = 1'b0;
    if (!rst) begin
      fd_flush_s  = 1'b1;
      dx_bubble_s = 1'b1;
    end else if (memwait_s) begin
      // Freeze everything, cnt included, until memory answers.
      xm_hold_s   = 1'b1;
      state_nxt_s = MWAIT;
      if (state_r != MWAIT) begin
        ret_nxt_s = state_r;
      end else begin
        ret_nxt_s = ret_state_r;
      end
    end else begin
      case (eff_state_s)
        RUN: begin
          pc_write_s = 1'b1;
          fd_write_s = 1'b1;
          if (X_branchTaken) begin
            // Branch also squashes any dependent decode instruction.
            fd_flush_s  = 1'b1;
            dx_bubble_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt_s = FLUSH;
              cnt_nxt_s   = FLUSH_INIT;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (loaduse_s) begin
            pc_write_s  = 1'b0;
            fd_write_s  = 1'b0;
            dx_bubble_s = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt_s = LSTALL;
              cnt_nxt_s   = LOAD_INIT;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LSTALL: begin
          dx_bubble_s = 1'b1;
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = LSTALL;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        FLUSH: begin
          pc_write_s  = 1'b1;
          fd_write_s  = 1'b1;
          fd_flush_s  = 1'b1;
          dx_bubble_s = 1'b1;
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          // A saved MWAIT cannot occur; recover to plain RUN.
          pc_write_s  = 1'b1;
          fd_write_s  = 1'b1;
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  assign pc_write  = pc_write_s;
  assign FD_write  = fd_write_s;
  assign FD_flush  = fd_flush_s;
  assign DX_bubble = dx_bubble_s;
  assign XM_hold   = xm_hold_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (rst & ~pc_write_s),
    .count (stall_count)
  );

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (rst & fd_flush_s),
    .count (flush_count)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (rst & xm_hold_s),
    .count (memwait_count)
  );
`else
  // Performance counters not built; only stall_count is present.
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller. The driver applies one
// cycle of stimulus, evaluates a behavioural model (remaining-bubble and
// remaining-flush counts, memory wait as a freeze) and queues the expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_stall_controller;

  localparam int LSC   = 3;
  localparam int FLC   = 2;
  localparam int CW    = 4;
  localparam int SAT_V = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    D_rs = 5'd0, D_rt = 5'd0, X_rd = 5'd0;
  logic          D_usesRt = 1'b0, X_memRead = 1'b0, X_branchTaken = 1'b0;
  logic          M_memReq = 1'b0, M_memReady = 1'b0;
  logic          pc_write, FD_write, FD_flush, DX_bubble, XM_hold;
  logic [CW-1:0] stall_count;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] flush_count, memwait_count;
`endif

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES (LSC),
    .FLUSH_CYCLES      (FLC),
    .CNT_W             (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .D_rs          (D_rs),
    .D_rt          (D_rt),
    .D_usesRt      (D_usesRt),
    .X_rd          (X_rd),
    .X_memRead     (X_memRead),
    .X_branchTaken (X_branchTaken),
    .M_memReq      (M_memReq),
    .M_memReady    (M_memReady),
    .pc_write      (pc_write),
    .FD_write      (FD_write),
    .FD_flush      (FD_flush),
    .DX_bubble     (DX_bubble),
    .XM_hold       (XM_hold),
    .stall_count   (stall_count)
`ifdef HAZARD_PERF_EN
    ,
    .flush_count   (flush_count),
    .memwait_count (memwait_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pc, fdw, fdf, dxb, xmh;
    int   sc, fc, mc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: cycles still owed after the current one, plus counters.
  int lbub_left = 0, flush_left = 0;
  int sc_m = 0, fc_m = 0, mc_m = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic step(input logic rv, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] rd, input logic mr,
                      input logic br, input logic req, input logic rdy);
    exp_t e;
    bit   mw, lu;
    @(posedge clk);
    #1;
    rst = rv; D_rs = rs; D_rt = rt; D_usesRt = ut; X_rd = rd;
    X_memRead = mr; X_branchTaken = br; M_memReq = req; M_memReady = rdy;
    if (!rv) begin
      lbub_left = 0; flush_left = 0; sc_m = 0; fc_m = 0; mc_m = 0;
      e = '{pc: 1'b0, fdw: 1'b0, fdf: 1'b1, dxb: 1'b1, xmh: 1'b0, sc: 0, fc: 0, mc: 0};
    end else begin
      mw = req && !rdy;
      lu = mr && (rd != 5'd0) && ((rd == rs) || (ut && (rd == rt)));
      e = '{pc: 1'b1, fdw: 1'b1, fdf: 1'b0, dxb: 1'b0, xmh: 1'b0, sc: sc_m, fc: fc_m, mc: mc_m};
      if (mw) begin
        e.pc = 1'b0; e.fdw = 1'b0; e.xmh = 1'b1;
      end else if (flush_left > 0) begin
        e.fdf = 1'b1; e.dxb = 1'b1; flush_left--;
      end else if (lbub_left > 0) begin
        e.pc = 1'b0; e.fdw = 1'b0; e.dxb = 1'b1; lbub_left--;
      end else if (br) begin
        e.fdf = 1'b1; e.dxb = 1'b1; flush_left = FLC - 1;
      end else if (lu) begin
        e.pc = 1'b0; e.fdw = 1'b0; e.dxb = 1'b1; lbub_left = LSC - 1;
      end
      if (!e.pc && sc_m < SAT_V) sc_m++;
      if (e.fdf && fc_m < SAT_V) fc_m++;
      if (e.xmh && mc_m < SAT_V) mc_m++;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every output the DUT presents against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pc_write",    int'(pc_write),    int'(e.pc));
      chk("FD_write",    int'(FD_write),    int'(e.fdw));
      chk("FD_flush",    int'(FD_flush),    int'(e.fdf));
      chk("DX_bubble",   int'(DX_bubble),   int'(e.dxb));
      chk("XM_hold",     int'(XM_hold),     int'(e.xmh));
      chk("stall_count", int'(stall_count), e.sc);
`ifdef HAZARD_PERF_EN
      chk("flush_count",   int'(flush_count),   e.fc);
      chk("memwait_count", int'(memwait_count), e.mc);
`endif
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs: three bubbles then RUN.
    step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    // $zero never stalls.
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // rt dependency counts only when rt is used.
    step(1'b1, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Branch together with load-use: flush wins.
    step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Memory wait during LSTALL, then finish the remaining bubbles.
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    // Reset in the middle of FLUSH, then release.
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Randomised blocks, each starting from reset.
    for (int b = 0; b < 8; b++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        step(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
    end
    // Saturation: 2^CNT_W+5 wait cycles.
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CW) + 5; i++) step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline hazard sequencer for the 5-stage MIPS core. It works alongside the forwarding unit and covers the hazards forwarding cannot resolve: load-use dependencies, taken-branch squash, and data-memory wait states. It drives the PC write enable, the IF/ID write enable and flush, the ID/EX bubble insert, and the EX/MEM hold. Registered FSM with Mealy outputs, so a stall takes effect in the same cycle the hazard is detected.

Parameters:
LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7).
FLUSH_CYCLES, 1, number of cycles IF/ID is squashed after a taken branch (1..7).
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-low
D_rs  input  5  decode-stage source register rs
D_rt  input  5  decode-stage source register rt
D_usesRt  input  1  decode instruction reads rt
X_rd  input  5  execute-stage destination register
X_memRead  input  1  execute-stage instruction is a load
X_branchTaken  input  1  branch resolved taken in EX
M_memReq  input  1  MEM stage is accessing data memory
M_memReady  input  1  data memory completes the access this cycle
pc_write  output  1  PC update enable
FD_write  output  1  IF/ID register enable
FD_flush  output  1  IF/ID register loads a NOP
DX_bubble  output  1  ID/EX register loads a NOP (control bits zeroed)
XM_hold  output  1  freezes the EX/MEM and MEM/WB registers
stall_count  output  CNT_W  cycles with pc_write=0

Behaviour:
- States: RUN, LSTALL, FLUSH, MWAIT. Registered signals: 3-bit down-counter cnt and ret_state.
- Reset asserted (rst=0): state=RUN, cnt=0, ret_state=RUN, counters=0. Outputs while in reset: pc_write=0, FD_write=0, FD_flush=1, DX_bubble=1, XM_hold=0. Reset mid-stall aborts immediately.
- Hazard terms:
  - memwait = M_memReq & ~M_memReady.
  - loaduse = X_memRead & (X_rd!=0) & ((X_rd==D_rs) | (D_usesRt & (X_rd==D_rt))).
- Priority in every state: memwait > branch > loaduse.
- Any state with memwait:
  - Outputs: pc_write=0, FD_write=0, FD_flush=0, DX_bubble=0, XM_hold=1.
  - If the current state is not MWAIT, save ret_state=current state and move to MWAIT. cnt is frozen.
- MWAIT:
  - Same outputs as above while memwait holds.
  - The first cycle with M_memReady=1 (or M_memReq=0) returns to ret_state and resumes that state's own output rule in that cycle.
- RUN:
  - Default outputs: pc_write=1, FD_write=1, others 0.
  - X_branchTaken: FD_flush=1, DX_bubble=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else loaduse: pc_write=0, FD_write=0, DX_bubble=1. If LOAD_STALL_CYCLES>1, go to LSTALL with cnt=LOAD_STALL_CYCLES-1.
  - Branch and loaduse together: branch wins, no load stall (the dependent instruction is squashed).
- LSTALL:
  - Outputs: pc_write=0, FD_write=0, DX_bubble=1.
  - cnt decrements; cnt==1 returns to RUN next cycle.
  - X_branchTaken is ignored (EX holds a bubble).
- FLUSH:
  - Outputs: pc_write=1, FD_write=1, FD_flush=1, DX_bubble=1.
  - cnt decrements; cnt==1 returns to RUN.
  - loaduse is ignored (the decode instruction is being squashed).
- stall_count: increments on every non-reset cycle with pc_write=0 and saturates at all-ones (no wrap).
- X_rd==0 never causes a load stall.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs flush_count[CNT_W] (cycles with FD_flush=1 outside reset) and memwait_count[CNT_W] (cycles with XM_hold=1). Both are saturating, reset to 0, and follow the same rules as stall_count.
- Undefined: ports and logic are absent; stall_count is unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum (RUN=2'd0, LSTALL=2'd1, FLUSH=2'd2, MWAIT=2'd3);
  - NOP encoding constant;
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W; inputs inc and clear; saturating), instanced per counter.

Test Plan:
1. Load-use: X_memRead=1, X_rd=8, D_rs=8, LOAD_STALL_CYCLES=1 -> one cycle with pc_write=0, FD_write=0, DX_bubble=1, then RUN; stall_count=1.
2. LOAD_STALL_CYCLES=3, loaduse pulse -> 3 consecutive bubble cycles, then pc_write=1; stall_count=3. With X_rd=0 and D_rs=0 -> no stall.
3. Branch together with loaduse, FLUSH_CYCLES=2 -> 2 cycles of FD_flush=1 and DX_bubble=1 with pc_write=1; stall_count unchanged.
4. In LSTALL with cnt=2, M_memReq=1 and M_memReady=0 for 4 cycles -> XM_hold=1 for 4 cycles, then return to LSTALL and finish the remaining 2 bubbles; stall_count=7 total.
5. rst driven low in the middle of FLUSH -> outputs go immediately to the reset values; after release, state is RUN with pc_write=1.
6. Force 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_count holds at 15. Under HAZARD_PERF_EN, memwait_count also saturates at 15.
